spi_slave: RTL
==============

# spi_slave

SPI mode-3 target (CPOL=1, CPHA=1, MSB first, CSN active low), the responder for the team's SPI master. It oversamples SCK, CSN and MOSI on `clk_in` and shifts in 1 to 32 bits per CSN-low frame. It drives MISO from a word latched at frame start. It reports the received word, its bit count and overrun status with a one-cycle strobe, and is used both as a loopback target in benches and as an FPGA-side register port.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on SCK, CSN and MOSI; legal range is 2..4.
- `clk_in`  in  1  logic clock; all state changes on its rising edge.
- `nrst`  in  1  reset, asynchronous, active-low; clock `clk_in`.
- `spi_sck`  in  1  SPI clock from the master; idles high.
- `spi_csn`  in  1  chip select, active low.
- `spi_mosi`  in  1  master data out, slave data in.
- `spi_miso`  out  1  slave data out (registered).
- `miso_oe`  out  1  MISO tristate enable; high while a frame is active.
- `tx_data`  in  32  response word; `tx_data[31]` is sent first.
- `rx_data`  out  32  received bits, right-aligned (last bit in `rx_data[0]`).
- `rx_nbits`  out  6  received bit count minus 1; 0 means 1 bit, 31 means 32 bits.
- `rx_overrun`  out  1  set when more than 32 SCK rising edges occurred in the frame.
- `rx_valid`  out  1  one-cycle strobe; `rx_data`, `rx_nbits` and `rx_overrun` are valid and held until the next strobe.
- `busy`  out  1  high while a frame is active.

## Operation
- Synchronizers: `SYNC_STAGES` flops per input, with reset values sck=1, csn=1, mosi=1. A one-flop history register per synchronized signal gives the rise and fall detects.
- State WAIT_IDLE (reset state):
  - stays here until synchronized CSN=1, then goes to IDLE;
  - purpose: a frame already in progress when reset releases is ignored.
- State IDLE, on CSN fall:
  - tx_shift <= tx_data; spi_miso <= tx_data[31]; miso_oe <= 1; busy <= 1;
  - rx_shift <= 0; bit_cnt <= 0;
  - goes to ACTIVE.
- State ACTIVE:
  - SCK fall: spi_miso <= tx_shift[31]; tx_shift <= tx_shift << 1, zero fill. Bits after the 32nd read as 0.
  - SCK rise: rx_shift <= {rx_shift[30:0], mosi_sync}; bit_cnt increments and saturates at 33. bit_cnt is 6 bits wide.
  - CSN rise: goes to DONE and takes priority over any SCK edge detected in the same cycle; that edge is dropped.
- State DONE (one cycle), then IDLE:
  - clears miso_oe and busy; spi_miso <= 1;
  - if bit_cnt ≥ 1: rx_valid <= 1 for one cycle; rx_data <= rx_shift; rx_nbits <= min(bit_cnt, 32) − 1; rx_overrun <= (bit_cnt == 33).
  - if bit_cnt == 0 (CSN pulse with no clocks): no strobe, and the rx outputs keep their previous values.
- `tx_data` is sampled only on CSN fall; changes during a frame have no effect.
- Reset values: spi_miso=1, miso_oe=0, rx_data=0, rx_nbits=0, rx_overrun=0, rx_valid=0, busy=0, state WAIT_IDLE.
- Reset mid-frame: outputs go to reset values immediately, with no strobe for the aborted frame.

## Timing
- Detect latency: a pin edge acts on the (SYNC_STAGES+1)-th `clk_in` rising edge after the edge.
- Master SCK half-period must be ≥ SYNC_STAGES+3 `clk_in` cycles. This keeps MISO stable before the master's sampling rise.
- CSN-high time between frames must be ≥ SYNC_STAGES+3 cycles.
- rx_valid rises SYNC_STAGES+2 cycles after the CSN pin rises.
- MOSI and SCK pass through identical synchronizer depth. MOSI, which changes at SCK fall, is therefore stable at the detected SCK rise.

## Structure
- Shared package `spi_pkg`:
  - state encoding (WAIT_IDLE, IDLE, ACTIVE, DONE);
  - `SPI_WORD_W` = 32 and `SPI_CNT_W` = 6;
  - idle levels: SCK=1, CSN=1, MISO=1.
- Sub-module `spi_sync_edge`: an N-stage synchronizer with registered rise/fall outputs and a parameterized reset level. Instantiated three times.

## Test plan
- Full word: master drives nbits=31, mosi_data=0xA5A51234; slave has tx_data=0xDEADBEEF.
  -> rx_data=0xA5A51234, rx_nbits=31, rx_overrun=0; exactly one rx_valid pulse; master miso_data=0xDEADBEEF.
- Short frame: nbits=7, mosi_data=0x5A, tx_data=0xC3000000.
  -> rx_data=0x0000005A, rx_nbits=7; master receives 0xC3.
- Back-to-back frames, with tx_data changed from 0x11111111 to 0x22222222 mid-frame 1.
  -> frame 1 returns 0x11111111, frame 2 returns 0x22222222; two strobes.
- Overrun: bench drives 34 SCK pulses with MOSI alternating 1,0 starting at 1.
  -> rx_overrun=1, rx_nbits=31, rx_data=0xAAAAAAAA.
- Reset mid-frame: nrst pulsed after 10 bits while CSN stays low.
  -> outputs at reset values, no strobe at the CSN rise; the next frame (nbits=15, 0xBEEF) yields rx_data=0x0000BEEF.
- CSN pulse with no SCK -> miso_oe pulses high, no rx_valid, rx outputs unchanged.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-3 target: word/count widths, bus idle
// levels, FSM state encoding and the received-length encoding helper.
package spi_pkg;

   localparam int SPI_WORD_W = 32;
   localparam int SPI_CNT_W  = 6;

   localparam logic SCK_IDLE  = 1'b1;
   localparam logic CSN_IDLE  = 1'b1;
   localparam logic MISO_IDLE = 1'b1;

   // One past a full word: any count at this value means the frame overran.
   localparam logic [SPI_CNT_W-1:0] CNT_SAT  = 6'd33;
   localparam logic [SPI_CNT_W-1:0] CNT_FULL = 6'd32;

   typedef enum logic [1:0] {
      ST_WAIT_IDLE,
      ST_IDLE,
      ST_ACTIVE,
      ST_DONE
   } spi_state_e;

   function automatic logic [SPI_CNT_W-1:0] nbits_code(input logic [SPI_CNT_W-1:0] cnt);
      return (cnt > CNT_FULL) ? (CNT_FULL - 6'd1) : (cnt - 6'd1);
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage input synchronizer with a one-flop history register; the rise/fall
// detects are built only from flop outputs, so they are glitch-free.
module spi_sync_edge
   import spi_pkg::*;
#(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk_in,
   input  logic nrst,
   input  logic i_d,
   output logic o_q,
   output logic o_rise,
   output logic o_fall
);

   logic [STAGES-1:0] r_sync;
   logic              r_hist;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_in or negedge nrst) begin
      if (!nrst) begin
         r_sync <= {STAGES{RST_VAL}};
         r_hist <= RST_VAL;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
         r_hist <= r_sync[STAGES-1];
      end
   end

   assign o_q    = r_sync[STAGES-1];
   assign o_rise = r_sync[STAGES-1] & ~r_hist;
   assign o_fall = ~r_sync[STAGES-1] & r_hist;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-3 target (CPOL=1, CPHA=1, MSB first): oversamples the bus on clk_in,
// receives 1..32 bits per frame and returns a word latched at frame start.
module spi_slave
   import spi_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk_in,
   input  logic                  nrst,
   input  logic                  spi_sck,
   input  logic                  spi_csn,
   input  logic                  spi_mosi,
   output logic                  spi_miso,
   output logic                  miso_oe,
   input  logic [SPI_WORD_W-1:0] tx_data,
   output logic [SPI_WORD_W-1:0] rx_data,
   output logic [SPI_CNT_W-1:0]  rx_nbits,
   output logic                  rx_overrun,
   output logic                  rx_valid,
   output logic                  busy
);

   localparam logic [2:0] FLUSH_CNT = 3'(SYNC_STAGES);

   logic w_sck_q, w_sck_rise, w_sck_fall;
   logic w_csn_q, w_csn_rise, w_csn_fall;
   logic w_mosi_q, w_mosi_rise, w_mosi_fall;
   logic w_unused;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SCK_IDLE)) u_sync_sck (
      .clk_in (clk_in),
      .nrst   (nrst),
      .i_d    (spi_sck),
      .o_q    (w_sck_q),
      .o_rise (w_sck_rise),
      .o_fall (w_sck_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CSN_IDLE)) u_sync_csn (
      .clk_in (clk_in),
      .nrst   (nrst),
      .i_d    (spi_csn),
      .o_q    (w_csn_q),
      .o_rise (w_csn_rise),
      .o_fall (w_csn_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_mosi (
      .clk_in (clk_in),
      .nrst   (nrst),
      .i_d    (spi_mosi),
      .o_q    (w_mosi_q),
      .o_rise (w_mosi_rise),
      .o_fall (w_mosi_fall)
   );

   assign w_unused = ^{w_sck_q, w_mosi_rise, w_mosi_fall};

   // The synchronizer resets to CSN idle, so the real pin level is only known
   // after it has been refilled; until then WAIT_IDLE must not trust w_csn_q.
   logic [2:0] r_flush_cnt;
   logic       w_flushed;

   always_ff @(posedge clk_in or negedge nrst) begin
      if (!nrst) begin
         r_flush_cnt <= 3'd0;
      end else if (r_flush_cnt != FLUSH_CNT) begin
         r_flush_cnt <= r_flush_cnt + 3'd1;
      end
   end

   assign w_flushed = (r_flush_cnt == FLUSH_CNT);

   spi_state_e r_state, w_state_nxt;
   logic       w_start, w_shift_out, w_shift_in, w_finish;

   always_ff @(posedge clk_in or negedge nrst) begin
      if (!nrst) r_state <= ST_WAIT_IDLE;
      else       r_state <= w_state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_shift_out = 1'b0;
      w_shift_in  = 1'b0;
      w_finish    = 1'b0;
      unique case (r_state)
         ST_WAIT_IDLE: begin
            if (w_flushed && w_csn_q) w_state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            if (w_csn_fall) begin
               w_start     = 1'b1;
               w_state_nxt = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (w_csn_rise) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_shift_out = w_sck_fall;
               w_shift_in  = w_sck_rise;
            end
         end
         ST_DONE: begin
            w_finish    = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_WAIT_IDLE;
      endcase
   end

   logic [SPI_WORD_W-1:0] r_tx_shift, r_rx_shift, r_rx_data;
   logic [SPI_CNT_W-1:0]  r_bit_cnt, r_rx_nbits;
   logic                  r_miso, r_oe, r_busy, r_rx_overrun, r_rx_valid;

   always_ff @(posedge clk_in or negedge nrst) begin
      if (!nrst) begin
         r_tx_shift   <= '0;
         r_rx_shift   <= '0;
         r_bit_cnt    <= '0;
         r_miso       <= MISO_IDLE;
         r_oe         <= 1'b0;
         r_busy       <= 1'b0;
         r_rx_data    <= '0;
         r_rx_nbits   <= '0;
         r_rx_overrun <= 1'b0;
         r_rx_valid   <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         if (w_start) begin
            r_tx_shift <= tx_data;
            r_miso     <= tx_data[SPI_WORD_W-1];
            r_oe       <= 1'b1;
            r_busy     <= 1'b1;
            r_rx_shift <= '0;
            r_bit_cnt  <= '0;
         end
         // Zero fill means bits beyond the 32nd go out as 0.
         if (w_shift_out) begin
            r_miso     <= r_tx_shift[SPI_WORD_W-1];
            r_tx_shift <= {r_tx_shift[SPI_WORD_W-2:0], 1'b0};
         end
         if (w_shift_in) begin
            r_rx_shift <= {r_rx_shift[SPI_WORD_W-2:0], w_mosi_q};
            if (r_bit_cnt != CNT_SAT) r_bit_cnt <= r_bit_cnt + 6'd1;
         end
         if (w_finish) begin
            r_oe   <= 1'b0;
            r_busy <= 1'b0;
            r_miso <= MISO_IDLE;
            if (r_bit_cnt != '0) begin
               r_rx_valid   <= 1'b1;
               r_rx_data    <= r_rx_shift;
               r_rx_nbits   <= nbits_code(r_bit_cnt);
               r_rx_overrun <= (r_bit_cnt == CNT_SAT);
            end
         end
      end
   end

   assign spi_miso   = r_miso;
   assign miso_oe    = r_oe;
   assign busy       = r_busy;
   assign rx_data    = r_rx_data;
   assign rx_nbits   = r_rx_nbits;
   assign rx_overrun = r_rx_overrun;
   assign rx_valid   = r_rx_valid;

endmodule
